// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: FSM encoding, counter width
// and the index-width helper.
package dmem_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam int unsigned CNT_W = 4;

    localparam int unsigned DEPTH_DEFAULT = 1024;

    function automatic int unsigned idx_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

    localparam int unsigned IDX_W_DEFAULT = idx_width(DEPTH_DEFAULT);

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM with registered read data and no reset, so it can map
// onto block RAM.
module dmem_array #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned IDX_W = 10
) (
    input  logic             clk,
    input  logic             we,
    input  logic             re,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[idx] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[idx];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, WAIT_STATES extra cycles,
// single-cycle dmem_ready pulse. Optional DMEM_FAULT_EN adds dmem_fault.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dmem_req,
    input  logic [31:0] dmem_addr,
    input  logic        dmem_write_en,
    input  logic [31:0] dmem_val_in,
    output logic [31:0] dmem_val_out,
`ifdef DMEM_FAULT_EN
    output logic        dmem_fault,
`endif
    output logic        dmem_ready
);

    localparam int unsigned IDX_W = idx_width(DEPTH);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             we_q, we_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             bad_q, bad_d;
    logic             ready_q, ready_d;
    logic             show_q, show_d;
    logic             fault_q, fault_d;
    logic             addr_bad;
    logic             access;
    logic             ram_we, ram_re;
    logic [31:0]      ram_rdata;

`ifdef DMEM_FAULT_EN
    assign addr_bad = (dmem_addr[1:0] != 2'b00) || ((dmem_addr >> (IDX_W + 2)) != 32'd0);
`else
    // Without fault checking the byte offset and bits above the index wrap away.
    logic unused_addr;
    assign unused_addr = ^{dmem_addr[31:IDX_W+2], dmem_addr[1:0]};
    assign addr_bad    = 1'b0;
`endif

    assign access = (state_q == BUSY) && (cnt_q == '0);
    assign ram_we = access && we_q && !bad_q;
    assign ram_re = access && !we_q && !bad_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        bad_d   = bad_q;
        show_d  = show_q;
        ready_d = 1'b0;
        fault_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (dmem_req) begin
                    idx_d   = dmem_addr[IDX_W+1:2];
                    we_d    = dmem_write_en;
                    wdata_d = dmem_val_in;
                    bad_d   = addr_bad;
                    cnt_d   = CNT_W'(WAIT_STATES);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    ready_d = 1'b1;
                    fault_d = bad_q;
                    state_d = RESP;
                    // show_q selects RAM read data; a faulted access forces zero.
                    if (bad_q) begin
                        show_d = 1'b0;
                    end else if (!we_q) begin
                        show_d = 1'b1;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            bad_q   <= 1'b0;
            ready_q <= 1'b0;
            show_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            bad_q   <= bad_d;
            ready_q <= ready_d;
            show_q  <= show_d;
            fault_q <= fault_d;
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .idx   (idx_q),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    assign dmem_val_out = show_q ? ram_rdata : 32'h0000_0000;
    assign dmem_ready   = ready_q;
`ifdef DMEM_FAULT_EN
    assign dmem_fault   = fault_q;
`else
    logic unused_fault;
    assign unused_fault = fault_q;
`endif

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder at the far end of the memory-stage data port.
- Accepts one load or store request at a time from the pipeline's memory stage and services it against an internal word array after a programmable number of wait states.
- Returns read data with a single-cycle ready pulse so the pipeline can stall on multi-cycle memory.

Parameters:
DEPTH, 1024, number of 32-bit words in the array (power of two)
WAIT_STATES, 0, extra cycles inserted between request capture and access (0..15)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
dmem_req  input  1  request valid; held high by requester until dmem_ready
dmem_addr  input  32  byte address; word index = dmem_addr[log2(DEPTH)+1:2]
dmem_write_en  input  1  1 = store, 0 = load
dmem_val_in  input  32  store data (requester's write-data output)
dmem_val_out  output  32  load data, valid while dmem_ready=1
dmem_ready  output  1  one-cycle completion pulse, loads and stores

Behaviour:
- Reset (async, active-high) forces: state IDLE, dmem_ready=0, dmem_val_out=0, wait counter=0, capture registers=0. Array contents are not reset.
- FSM states: IDLE, BUSY, RESP.
- IDLE: at a rising edge with dmem_req=1, capture addr, write_en and write data; load counter with WAIT_STATES; go to BUSY. If dmem_req=0, stay in IDLE.
- BUSY, counter!=0: decrement, stay in BUSY.
- BUSY, counter==0, access edge:
  - Store: write captured data to array[index]; dmem_val_out unchanged.
  - Load: dmem_val_out <= array[index].
  - dmem_ready <= 1; go to RESP.
- RESP: dmem_ready <= 0; go to IDLE. dmem_req is ignored in RESP.
- Latency: request sampled at edge N; dmem_ready is high during the cycle following edge N+1+WAIT_STATES. WAIT_STATES=0 gives ready two cycles after the request is first presented.
- Back-to-back: minimum issue interval is WAIT_STATES+3 cycles. A request still high in the cycle after the ready pulse is a new transaction and is captured in IDLE.
- Inputs changing after capture have no effect on the in-flight access.
- Load after store to the same word returns the stored value. No hazard is possible because only one request is outstanding.
- Address wrap: upper address bits above the index are ignored, so the address wraps modulo DEPTH*4. Bits [1:0] are ignored (word access only).
- Reset mid-operation: transaction aborted. The store is not committed unless its access edge already occurred. dmem_ready is never asserted for the aborted request.
- dmem_val_out holds its last load value between loads.

Optional Feature:
- Macro DMEM_FAULT_EN.
- Defined:
  - Adds output dmem_fault (1 bit, reset 0).
  - At the access edge, if dmem_addr[1:0]!=0 or any address bit above the index is set, the access is suppressed: no write, and dmem_val_out <= 32'h0000_0000.
  - dmem_fault pulses together with dmem_ready.
- Undefined: the port is absent and the wrap/ignore rules above apply.

Decomposition:
- Package dmem_pkg holds:
  - FSM state encoding (IDLE=2'd0, BUSY=2'd1, RESP=2'd2)
  - index-width constant derived from DEPTH
  - WAIT_STATES counter width (4)
- Sub-module dmem_array holds the storage: single-port synchronous RAM with write enable, index, write data and registered read data. It has no reset, so it can map to block RAM.
- dmem_responder holds the FSM, counter, capture registers and the optional fault logic.

Test Plan:
- Reset release, WAIT_STATES=0: store 32'hDEADBEEF at 0x10, then load 0x10. Expect ready 2 cycles after each request and dmem_val_out=32'hDEADBEEF on the load ready cycle.
- WAIT_STATES=3: load from 0x20 preloaded with 32'h12345678. Expect ready exactly 5 cycles after request and no ready in the intervening cycles.
- Request held high continuously, alternating addr 0x0/0x4 loads. Expect one ready pulse every WAIT_STATES+3 cycles, with no duplicate or missed transactions.
- Change dmem_addr and dmem_val_in one cycle after capture of a store to 0x8 with data 32'hA5A5A5A5. Expect array[2]=32'hA5A5A5A5 and the new values ignored.
- Assert rst while in BUSY for a store to 0xC with WAIT_STATES=2. Expect dmem_ready=0 immediately, array[3] unchanged, and the FSM in IDLE after release.
- DMEM_FAULT_EN, DEPTH=1024: load 0x1002 (misaligned) and 0x1000 (out of range). Expect dmem_fault=1 with dmem_ready, dmem_val_out=0, and no write on the equivalent stores.
